// File: rtl/ofifo_pkg.sv
// Shared types and helpers for the output-FIFO read scheduler.
package ofifo_pkg;

    typedef enum logic [0:0] {IDLE = 1'b0, ROW_RUN = 1'b1} sched_state_t;

    localparam logic MODE_RR  = 1'b0;
    localparam logic MODE_ROW = 1'b1;

    function automatic logic [31:0] onehot(input int idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/ofifo_rd_sched_rr_arbiter.sv
// Combinational round-robin grant: first requester at or after ptr, scanning upward with wrap.
module rr_arbiter #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);
    import ofifo_pkg::*;

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = IDX_W'((32'(ptr) + 32'(i)) % 32'(N));
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
                gnt     = N'(onehot(int'(idx)));
            end
        end
    end

endmodule

// File: rtl/ofifo_rd_sched.sv
// Read-side scheduler for a bank of column FIFOs: round-robin or lockstep row draining
// onto a single valid/ready port, accounting for the FIFOs' registered read latency.
//
//   state   | meaning
//   IDLE    | RR arbitration, or waiting for every column to be non-empty to start a row
//   ROW_RUN | issuing columns col_idx..NUM_FIFO-1 of the current row in order
module ofifo_rd_sched
    import ofifo_pkg::*;
#(
    parameter int NUM_FIFO  = 8,
    parameter int BW        = 20,
    parameter int ROW_CNT_W = 8,
    parameter int IDX_W     = $clog2(NUM_FIFO)
) (
    input  logic                   rd_clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   mode,
    input  logic [NUM_FIFO-1:0]    fifo_empty,
    input  logic [NUM_FIFO*BW-1:0] fifo_dout,
    output logic [NUM_FIFO-1:0]    fifo_rd,
    output logic [BW-1:0]          out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IDX_W-1:0]       out_src,
    output logic                   row_done,
    output logic [ROW_CNT_W-1:0]   row_cnt,
    output logic                   busy
);

    localparam logic [0:0]       ST_IDLE    = IDLE;
    localparam logic [0:0]       ST_ROW_RUN = ROW_RUN;
    localparam logic [IDX_W-1:0] LAST_COL   = IDX_W'(NUM_FIFO - 1);

    logic [0:0]          state, next_state;
    logic [IDX_W-1:0]    col_idx, next_col;
    logic [IDX_W-1:0]    rr_ptr, next_ptr;
    logic                out_last;
    logic                slot_free, can_issue;
    logic                issue, issue_last;
    logic [IDX_W-1:0]    issue_idx;
    logic [NUM_FIFO-1:0] rr_gnt;
    logic [IDX_W-1:0]    rr_idx;
    logic [BW-1:0]       dout_arr [NUM_FIFO];

    for (genvar g = 0; g < NUM_FIFO; g++) begin : g_dout
        assign dout_arr[g] = fifo_dout[g*BW +: BW];
    end

    rr_arbiter #(.N(NUM_FIFO), .IDX_W(IDX_W)) u_rr_arbiter (
        .req     (~fifo_empty),
        .ptr     (rr_ptr),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx)
    );

    assign slot_free = !out_valid || out_ready;
    assign can_issue = en && slot_free && !reset;

    // Columns are not re-checked for emptiness inside a row: all held a word at row start.
    always_comb begin
        issue      = 1'b0;
        issue_idx  = '0;
        issue_last = 1'b0;
        next_state = state;
        next_col   = col_idx;
        next_ptr   = rr_ptr;
        if (can_issue) begin
            if (state == ST_ROW_RUN) begin
                issue      = 1'b1;
                issue_idx  = col_idx;
                issue_last = (col_idx == LAST_COL);
                if (issue_last) begin
                    next_col   = '0;
                    next_state = ST_IDLE;
                end else begin
                    next_col = col_idx + 1'b1;
                end
            end else if (mode == MODE_ROW) begin
                if (fifo_empty == '0) begin
                    issue      = 1'b1;
                    next_col   = IDX_W'(1);
                    next_state = ST_ROW_RUN;
                end
            end else if (rr_gnt != '0) begin
                issue     = 1'b1;
                issue_idx = rr_idx;
                next_ptr  = (rr_idx == LAST_COL) ? '0 : rr_idx + 1'b1;
            end
        end
    end

    assign fifo_rd  = issue ? NUM_FIFO'(onehot(int'(issue_idx))) : '0;
    assign out_data = dout_arr[out_src];
    assign row_done = out_valid && out_ready && out_last && !reset;
    assign busy     = out_valid || (state == ST_ROW_RUN);

    always_ff @(posedge rd_clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            col_idx   <= '0;
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_src   <= '0;
            out_last  <= 1'b0;
            row_cnt   <= '0;
        end else begin
            state   <= next_state;
            col_idx <= next_col;
            rr_ptr  <= next_ptr;
            if (issue) begin
                out_valid <= 1'b1;
                out_src   <= issue_idx;
                out_last  <= issue_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (row_done) begin
                row_cnt <= row_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ofifo_rd_sched.sv
// Directed bench for ofifo_rd_sched with a behavioural model of 8 registered-read FIFOs.
module tb_ofifo_rd_sched;

    localparam int NF = 8;
    localparam int BW = 20;
    localparam int RW = 8;
    localparam int IW = 3;

    logic             rd_clk = 1'b0;
    logic             reset, en, mode, out_ready;
    logic [NF-1:0]    fifo_empty, fifo_rd;
    logic [NF*BW-1:0] fifo_dout;
    logic [BW-1:0]    out_data;
    logic             out_valid, row_done, busy;
    logic [IW-1:0]    out_src;
    logic [RW-1:0]    row_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [BW-1:0] mem [NF][16];
    logic [BW-1:0] dout_q [NF];
    int            wp [NF];
    int            rp [NF];
    int            bad_rd   = 0;
    int            multi_rd = 0;

    ofifo_rd_sched #(.NUM_FIFO(NF), .BW(BW), .ROW_CNT_W(RW)) dut (
        .rd_clk     (rd_clk),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd    (fifo_rd),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_src    (out_src),
        .row_done   (row_done),
        .row_cnt    (row_cnt),
        .busy       (busy)
    );

    always #5 rd_clk = ~rd_clk;

    for (genvar g = 0; g < NF; g++) begin : g_model
        assign fifo_empty[g]           = (wp[g] == rp[g]);
        assign fifo_dout[g*BW +: BW]   = dout_q[g];
    end

    always @(posedge rd_clk) begin
        if ($countones(fifo_rd) > 1) multi_rd <= multi_rd + 1;
        for (int i = 0; i < NF; i++) begin
            if (fifo_rd[i]) begin
                if (wp[i] == rp[i]) begin
                    bad_rd <= bad_rd + 1;
                end else begin
                    dout_q[i] <= mem[i][rp[i] % 16];
                    rp[i]     <= rp[i] + 1;
                end
            end
        end
    end

    function automatic logic [BW-1:0] w(input int i, input int k);
        return {4'(i), 16'(k)};
    endfunction

    task automatic step();
        @(negedge rd_clk);
        #1;
    endtask

    task automatic push(input int i, input logic [BW-1:0] d);
        mem[i][wp[i] % 16] = d;
        wp[i] = wp[i] + 1;
    endtask

    task automatic flush();
        for (int i = 0; i < NF; i++) wp[i] = rp[i];
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0; mode = 1'b0; out_ready = 1'b1;
        flush();
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; mode = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < NF; i++) push(i, w(i, 9));
        #1;
        n_checks++; if (fifo_rd !== 8'h00) begin n_errors++; $display("FAIL rst_rd_held: got %h expected 00", fifo_rd); end
        step();
        step();
        n_checks++; if (fifo_rd !== 8'h00) begin n_errors++; $display("FAIL rst_rd: got %h expected 00", fifo_rd); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_src !== 3'd0) begin n_errors++; $display("FAIL rst_src: got %0d expected 0", out_src); end
        n_checks++; if (row_done !== 1'b0) begin n_errors++; $display("FAIL rst_row_done: got %b expected 0", row_done); end
        n_checks++; if (row_cnt !== 8'd0) begin n_errors++; $display("FAIL rst_row_cnt: got %0d expected 0", row_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        en = 1'b0;
        flush();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_single_fifo();
        do_reset();
        push(3, w(3, 16'hA));
        push(3, w(3, 16'hB));
        en = 1'b1;
        #1;
        n_checks++; if (fifo_rd !== 8'h08) begin n_errors++; $display("FAIL t1_rd0: got %h expected 08", fifo_rd); end
        step();
        n_checks++; if (fifo_rd !== 8'h08) begin n_errors++; $display("FAIL t1_rd1: got %h expected 08", fifo_rd); end
        n_checks++; if (out_valid !== 1'b1 || out_src !== 3'd3) begin n_errors++; $display("FAIL t1_a_vs: got v=%b src=%0d expected v=1 src=3", out_valid, out_src); end
        n_checks++; if (out_data !== w(3, 16'hA)) begin n_errors++; $display("FAIL t1_a_data: got %h expected %h", out_data, w(3, 16'hA)); end
        step();
        n_checks++; if (fifo_rd !== 8'h00) begin n_errors++; $display("FAIL t1_rd2: got %h expected 00", fifo_rd); end
        n_checks++; if (out_valid !== 1'b1 || out_data !== w(3, 16'hB)) begin n_errors++; $display("FAIL t1_b: got v=%b data=%h expected v=1 data=%h", out_valid, out_data, w(3, 16'hB)); end
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL t1_drain: got %b expected 0", out_valid); end
        en = 1'b0;
    endtask

    task automatic test_rr_all();
        logic [NF-1:0] exp_rd;
        do_reset();
        for (int i = 0; i < NF; i++) begin
            push(i, w(i, 0));
            push(i, w(i, 1));
        end
        en = 1'b1;
        #1;
        for (int k = 0; k < 9; k++) begin
            exp_rd = '0;
            exp_rd[k % NF] = 1'b1;
            n_checks++; if (fifo_rd !== exp_rd) begin n_errors++; $display("FAIL t2_rd k=%0d: got %h expected %h", k, fifo_rd, exp_rd); end
            step();
            n_checks++; if (out_src !== IW'(k % NF) || out_data !== w(k % NF, k / NF)) begin
                n_errors++; $display("FAIL t2_out k=%0d: got src=%0d data=%h expected src=%0d data=%h", k, out_src, out_data, k % NF, w(k % NF, k / NF));
            end
        end
        en = 1'b0;
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL t2_drain: got %b expected 0", out_valid); end
        flush();
    endtask

    task automatic test_backpressure();
        do_reset();
        push(2, w(2, 0)); push(2, w(2, 1));
        push(6, w(6, 0)); push(6, w(6, 1));
        out_ready = 1'b0;
        en = 1'b1;
        #1;
        n_checks++; if (fifo_rd !== 8'h04) begin n_errors++; $display("FAIL t3_rd0: got %h expected 04", fifo_rd); end
        step();
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (fifo_rd !== 8'h00 || out_valid !== 1'b1 || out_src !== 3'd2 || out_data !== w(2, 0)) begin
                n_errors++; $display("FAIL t3_hold c=%0d: got rd=%h v=%b src=%0d data=%h expected rd=00 v=1 src=2 data=%h", c, fifo_rd, out_valid, out_src, out_data, w(2, 0));
            end
            if (c < 4) step();
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (fifo_rd !== 8'h40) begin n_errors++; $display("FAIL t3_release: got %h expected 40", fifo_rd); end
        step();
        n_checks++; if (out_src !== 3'd6 || out_data !== w(6, 0)) begin n_errors++; $display("FAIL t3_next: got src=%0d data=%h expected src=6 data=%h", out_src, out_data, w(6, 0)); end
        en = 1'b0;
        step();
        flush();
    endtask

    task automatic test_row();
        logic [NF-1:0] exp_rd;
        do_reset();
        for (int i = 0; i < NF; i++) if (i != 5) push(i, w(i, 4));
        mode = 1'b1;
        en = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_checks++; if (fifo_rd !== 8'h00 || busy !== 1'b0) begin n_errors++; $display("FAIL t4_wait c=%0d: got rd=%h busy=%b expected rd=00 busy=0", c, fifo_rd, busy); end
            step();
        end
        push(5, w(5, 4));
        #1;
        for (int k = 0; k < NF; k++) begin
            exp_rd = '0;
            exp_rd[k] = 1'b1;
            n_checks++; if (fifo_rd !== exp_rd) begin n_errors++; $display("FAIL t4_rd k=%0d: got %h expected %h", k, fifo_rd, exp_rd); end
            step();
            n_checks++; if (out_src !== IW'(k) || out_data !== w(k, 4) || row_done !== (k == NF - 1)) begin
                n_errors++; $display("FAIL t4_out k=%0d: got src=%0d data=%h done=%b expected src=%0d data=%h done=%b", k, out_src, out_data, row_done, k, w(k, 4), (k == NF - 1));
            end
        end
        step();
        n_checks++; if (row_done !== 1'b0 || row_cnt !== 8'd1) begin n_errors++; $display("FAIL t4_cnt: got done=%b cnt=%0d expected done=0 cnt=1", row_done, row_cnt); end
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || fifo_rd !== 8'h00) begin n_errors++; $display("FAIL t4_idle: got v=%b busy=%b rd=%h expected 0 0 00", out_valid, busy, fifo_rd); end
        en = 1'b0;
    endtask

    task automatic test_row_pause();
        logic [NF-1:0] exp_rd;
        int            done_cnt;
        do_reset();
        for (int i = 0; i < NF; i++) push(i, w(i, 5));
        mode = 1'b1;
        en = 1'b1;
        done_cnt = 0;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_rd = '0;
            exp_rd[k] = 1'b1;
            n_checks++; if (fifo_rd !== exp_rd) begin n_errors++; $display("FAIL t5_rd k=%0d: got %h expected %h", k, fifo_rd, exp_rd); end
            step();
        end
        en = 1'b0;
        #1;
        n_checks++; if (fifo_rd !== 8'h00 || out_valid !== 1'b1 || out_src !== 3'd3 || out_data !== w(3, 5)) begin
            n_errors++; $display("FAIL t5_word3: got rd=%h v=%b src=%0d data=%h expected rd=00 v=1 src=3 data=%h", fifo_rd, out_valid, out_src, out_data, w(3, 5));
        end
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++; if (fifo_rd !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b1) begin
                n_errors++; $display("FAIL t5_pause c=%0d: got rd=%h v=%b busy=%b expected rd=00 v=0 busy=1", c, fifo_rd, out_valid, busy);
            end
        end
        en = 1'b1;
        #1;
        for (int k = 4; k < NF; k++) begin
            exp_rd = '0;
            exp_rd[k] = 1'b1;
            n_checks++; if (fifo_rd !== exp_rd) begin n_errors++; $display("FAIL t5_resume k=%0d: got %h expected %h", k, fifo_rd, exp_rd); end
            step();
            if (row_done === 1'b1) done_cnt++;
            n_checks++; if (out_src !== IW'(k) || out_data !== w(k, 5)) begin n_errors++; $display("FAIL t5_out k=%0d: got src=%0d data=%h expected src=%0d data=%h", k, out_src, out_data, k, w(k, 5)); end
        end
        step();
        n_checks++; if (row_cnt !== 8'd1 || done_cnt != 1 || busy !== 1'b0) begin
            n_errors++; $display("FAIL t5_cnt: got cnt=%0d pulses=%0d busy=%b expected cnt=1 pulses=1 busy=0", row_cnt, done_cnt, busy);
        end
        en = 1'b0;
    endtask

    task automatic test_reset_mid_row();
        do_reset();
        for (int i = 0; i < NF; i++) begin
            push(i, w(i, 6));
            push(i, w(i, 7));
        end
        mode = 1'b1;
        en = 1'b1;
        #1;
        for (int s = 0; s < 13; s++) step();
        n_checks++; if (fifo_rd !== 8'h20 || row_cnt !== 8'd1) begin n_errors++; $display("FAIL t6_pre: got rd=%h cnt=%0d expected rd=20 cnt=1", fifo_rd, row_cnt); end
        reset = 1'b1;
        #1;
        n_checks++; if (fifo_rd !== 8'h00) begin n_errors++; $display("FAIL t6_rd_in_reset: got %h expected 00", fifo_rd); end
        step();
        reset = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || fifo_rd !== 8'h00) begin n_errors++; $display("FAIL t6_out: got v=%b rd=%h expected v=0 rd=00", out_valid, fifo_rd); end
        n_checks++; if (row_cnt !== 8'd0 || busy !== 1'b0) begin n_errors++; $display("FAIL t6_state: got cnt=%0d busy=%b expected cnt=0 busy=0", row_cnt, busy); end
        n_checks++; if (wp[5] - rp[5] != 1) begin n_errors++; $display("FAIL t6_fifo5_left: got %0d expected 1", wp[5] - rp[5]); end
        en = 1'b0;
        step();
        flush();
    endtask

    task automatic test_integrity();
        n_checks++; if (bad_rd != 0) begin n_errors++; $display("FAIL rd_on_empty: got %0d expected 0", bad_rd); end
        n_checks++; if (multi_rd != 0) begin n_errors++; $display("FAIL multi_strobe: got %0d expected 0", multi_rd); end
    endtask

    initial begin
        for (int i = 0; i < NF; i++) begin
            wp[i] = 0;
            dout_q[i] = '0;
        end
        reset = 1'b1; en = 1'b0; mode = 1'b0; out_ready = 1'b1;
        step();
        test_reset();
        test_single_fifo();
        test_rr_all();
        test_backpressure();
        test_row();
        test_row_pause();
        test_reset_mid_row();
        test_integrity();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        for (int i = 0; i < NF; i++) rp[i] = 0;
    end

endmodule
